// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_stage : MEM/WB pipeline register, load extension and RegFile writeback    |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int CNT_W      = 32,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [31:0]      mem_pc,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic [31:0]      mem_alu_result,
  input  logic [31:0]      mem_load_data,
  input  logic [2:0]       mem_load_type,
  output logic [4:0]       write_addr,
  output logic [31:0]      write_data,
  output logic             write_enabled,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic [31:0]      wb_pc,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0]       c_LT_LH  = 3'd1;
  localparam logic [2:0]       c_LT_LHU = 3'd2;
  localparam logic [2:0]       c_LT_LB  = 3'd3;
  localparam logic [2:0]       c_LT_LBU = 3'd4;
  localparam logic [CNT_W-1:0] c_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q;
  logic             done_q;
  logic             reg_write_q;
  logic             mis_q;
  logic [4:0]       rd_q;
  logic [31:0]      result_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] retire_count_q;

  logic [31:0]      result_d;
  logic             mis_d;
  logic [1:0]       w_off;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_r0_blocked;
  logic             w_presenting;
  logic             w_retire;

  // Result is fully extended before capture so WB only muxes registers.
  always_comb begin
    w_off    = mem_alu_result[1:0];
    w_half   = w_off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (w_off)
      2'd0:    w_byte = mem_load_data[7:0];
      2'd1:    w_byte = mem_load_data[15:8];
      2'd2:    w_byte = mem_load_data[23:16];
      default: w_byte = mem_load_data[31:24];
    endcase
    result_d = mem_alu_result;
    mis_d    = 1'b0;
    if (mem_mem_to_reg) begin
      case (mem_load_type)
        c_LT_LH: begin
          result_d = {{16{w_half[15]}}, w_half};
          mis_d    = w_off[0];
        end
        c_LT_LHU: begin
          result_d = {16'h0000, w_half};
          mis_d    = w_off[0];
        end
        c_LT_LB:  result_d = {{24{w_byte[7]}}, w_byte};
        c_LT_LBU: result_d = {24'h000000, w_byte};
        default: begin
          result_d = mem_load_data;
          mis_d    = (w_off != 2'd0);
        end
      endcase
    end
  end

  always_comb begin
    w_r0_blocked = PROTECT_R0 && (rd_q == 5'd0);
    w_presenting = valid_q && !done_q;
    w_retire     = w_presenting && !mis_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      reg_write_q    <= 1'b0;
      mis_q          <= 1'b0;
      rd_q           <= 5'd0;
      result_q       <= 32'd0;
      pc_q           <= 32'd0;
      retire_count_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (!stall) begin
        valid_q     <= mem_valid;
        done_q      <= 1'b0;
        reg_write_q <= mem_reg_write;
        mis_q       <= mis_d;
        rd_q        <= mem_rd;
        result_q    <= result_d;
        pc_q        <= mem_pc;
      end else begin
        // Any held entry has been presented once; mark it so it never repeats.
        done_q <= done_q | valid_q;
      end
      if (w_retire) begin
        retire_count_q <= retire_count_q + c_ONE;
      end
    end
  end

  always_comb begin
    write_enabled = w_presenting && reg_write_q && !mis_q && !w_r0_blocked;
    misalign_exc  = w_presenting && mis_q;
    write_addr    = valid_q ? rd_q : 5'd0;
    write_data    = valid_q ? result_q : 32'd0;
    wb_pc         = valid_q ? pc_q : 32'd0;
    fwd_valid     = write_enabled;
    fwd_addr      = write_addr;
    fwd_data      = write_data;
    retire_count  = retire_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_stage : self-checking bench for wb_stage                               |
// | Revision    : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_wb_stage;

  typedef struct {
    logic [2:0]  lt;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        we;
    logic        we_np;
    logic        mis;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        we;
    logic        we_np;
    logic        mis;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = 32'd0;
  logic [4:0]  mem_rd = 5'd0;
  logic        mem_reg_write = 1'b0;
  logic        mem_mem_to_reg = 1'b0;
  logic [31:0] mem_alu_result = 32'd0;
  logic [31:0] mem_load_data = 32'd0;
  logic [2:0]  mem_load_type = 3'd0;

  logic [4:0]  write_addr, fwd_addr, np_write_addr, np_fwd_addr;
  logic [31:0] write_data, fwd_data, wb_pc, np_write_data, np_fwd_data, np_wb_pc;
  logic        write_enabled, fwd_valid, misalign_exc;
  logic        np_write_enabled, np_fwd_valid, np_misalign_exc;
  logic [31:0] retire_count;
  logic [2:0]  np_retire_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_count = 32'd0;
  exp_t sb[$];
  vec_t vecs[19];

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32), .PROTECT_R0(1'b1)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_load_type(mem_load_type),
    .write_addr(write_addr), .write_data(write_data), .write_enabled(write_enabled),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_pc(wb_pc),
    .misalign_exc(misalign_exc), .retire_count(retire_count)
  );

  // Second instance: no r0 protection, narrow counter to exercise wraparound.
  wb_stage #(.CNT_W(3), .PROTECT_R0(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_load_type(mem_load_type),
    .write_addr(np_write_addr), .write_data(np_write_data), .write_enabled(np_write_enabled),
    .fwd_valid(np_fwd_valid), .fwd_addr(np_fwd_addr), .fwd_data(np_fwd_data), .wb_pc(np_wb_pc),
    .misalign_exc(np_misalign_exc), .retire_count(np_retire_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] lt, input logic m2r, input logic rw,
                              input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                              input logic we, input logic we_np, input logic mis,
                              input logic [31:0] data);
    vec_t v;
    v.lt = lt; v.m2r = m2r; v.rw = rw; v.rd = rd; v.alu = alu; v.ld = ld;
    v.we = we; v.we_np = we_np; v.mis = mis; v.data = data;
    return v;
  endfunction

  task automatic drive(input logic [2:0] lt, input logic m2r, input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
    mem_valid = 1'b1; mem_load_type = lt; mem_mem_to_reg = m2r; mem_reg_write = rw;
    mem_rd = rd; mem_alu_result = alu; mem_load_data = ld; mem_pc = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n_hi;
    int   n_mis;
    exp_t e;

    vecs[0]  = mk(3'd0, 1'b0, 1'b1, 5'd5,  32'h1234_5678, 32'hDEAD_BEEF, 1, 1, 0, 32'h1234_5678);
    vecs[1]  = mk(3'd3, 1'b1, 1'b1, 5'd3,  32'h0000_1003, 32'h80FF_7F01, 1, 1, 0, 32'hFFFF_FF80);
    vecs[2]  = mk(3'd4, 1'b1, 1'b1, 5'd4,  32'h0000_1002, 32'h80FF_7F01, 1, 1, 0, 32'h0000_00FF);
    vecs[3]  = mk(3'd1, 1'b1, 1'b1, 5'd6,  32'h0000_1002, 32'h80FF_7F01, 1, 1, 0, 32'hFFFF_80FF);
    vecs[4]  = mk(3'd2, 1'b1, 1'b1, 5'd8,  32'h0000_1000, 32'h80FF_7F01, 1, 1, 0, 32'h0000_7F01);
    vecs[5]  = mk(3'd3, 1'b1, 1'b1, 5'd9,  32'h0000_1001, 32'h80FF_7F01, 1, 1, 0, 32'h0000_007F);
    vecs[6]  = mk(3'd4, 1'b1, 1'b1, 5'd9,  32'h0000_1000, 32'h80FF_7F01, 1, 1, 0, 32'h0000_0001);
    vecs[7]  = mk(3'd0, 1'b1, 1'b1, 5'd10, 32'h0000_2000, 32'h80FF_7F01, 1, 1, 0, 32'h80FF_7F01);
    vecs[8]  = mk(3'd0, 1'b1, 1'b1, 5'd7,  32'h0000_2002, 32'h80FF_7F01, 0, 0, 1, 32'h80FF_7F01);
    vecs[9]  = mk(3'd1, 1'b1, 1'b1, 5'd11, 32'h0000_2001, 32'h1234_F00D, 0, 0, 1, 32'hFFFF_F00D);
    vecs[10] = mk(3'd2, 1'b1, 1'b1, 5'd11, 32'h0000_2003, 32'h1234_F00D, 0, 0, 1, 32'h0000_1234);
    vecs[11] = mk(3'd1, 1'b1, 1'b1, 5'd12, 32'h0000_2000, 32'h1234_F00D, 1, 1, 0, 32'hFFFF_F00D);
    vecs[12] = mk(3'd2, 1'b1, 1'b1, 5'd12, 32'h0000_2002, 32'h1234_F00D, 1, 1, 0, 32'h0000_1234);
    vecs[13] = mk(3'd0, 1'b0, 1'b1, 5'd0,  32'hCAFE_F00D, 32'h0000_0000, 0, 1, 0, 32'hCAFE_F00D);
    vecs[14] = mk(3'd0, 1'b0, 1'b0, 5'd12, 32'h0000_0003, 32'h0000_0000, 0, 0, 0, 32'h0000_0003);
    vecs[15] = mk(3'd5, 1'b1, 1'b1, 5'd14, 32'h0000_0004, 32'hA5A5_A5A5, 1, 1, 0, 32'hA5A5_A5A5);
    vecs[16] = mk(3'd7, 1'b1, 1'b1, 5'd15, 32'h0000_0005, 32'hA5A5_A5A5, 0, 0, 1, 32'hA5A5_A5A5);
    vecs[17] = mk(3'd0, 1'b0, 1'b1, 5'd16, 32'h0000_0003, 32'hFFFF_FFFF, 1, 1, 0, 32'h0000_0003);
    vecs[18] = mk(3'd3, 1'b1, 1'b1, 5'd17, 32'h0000_0002, 32'h80FF_7F01, 1, 1, 0, 32'hFFFF_FFFF);

    // Reset held with valid traffic on the inputs: everything stays zero.
    drive(3'd0, 1'b0, 1'b1, 5'd5, 32'h1111_1111, 32'd0, 32'h0000_0100);
    repeat (3) @(negedge clk);
    chk("rst_we", {31'd0, write_enabled}, 32'd0);
    chk("rst_addr", {27'd0, write_addr}, 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_pc", wb_pc, 32'd0);
    chk("rst_count", retire_count, 32'd0);
    rst = 1'b1;
    mem_valid = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].lt, vecs[i].m2r, vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].ld,
            32'h0040_0000 + 32'(4 * i));
      e.we = vecs[i].we; e.we_np = vecs[i].we_np; e.mis = vecs[i].mis;
      e.addr = vecs[i].rd; e.data = vecs[i].data; e.pc = 32'h0040_0000 + 32'(4 * i);
      sb.push_back(e);
      @(negedge clk);
      mem_valid = 1'b0;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_we", i), {31'd0, write_enabled}, {31'd0, e.we});
        chk($sformatf("v%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, e.we});
        chk($sformatf("v%0d_we_np", i), {31'd0, np_write_enabled}, {31'd0, e.we_np});
        chk($sformatf("v%0d_mis", i), {31'd0, misalign_exc}, {31'd0, e.mis});
        chk($sformatf("v%0d_addr", i), {27'd0, write_addr}, {27'd0, e.addr});
        chk($sformatf("v%0d_data", i), write_data, e.data);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, e.data);
        chk($sformatf("v%0d_pc", i), wb_pc, e.pc);
        chk($sformatf("v%0d_count", i), retire_count, exp_count);
        chk($sformatf("v%0d_count_np", i), {29'd0, np_retire_count}, {29'd0, exp_count[2:0]});
        if (!e.mis) exp_count = exp_count + 32'd1;
      end
    end
    @(negedge clk);
    chk("bubble_we", {31'd0, write_enabled}, 32'd0);
    chk("bubble_data", write_data, 32'd0);
    chk("table_count", retire_count, exp_count);
    chk("table_count_wrap", {29'd0, np_retire_count}, {29'd0, exp_count[2:0]});

    // Writing entry held by stall: presented exactly once, counted once.
    drive(3'd0, 1'b0, 1'b1, 5'd13, 32'hAAAA_0001, 32'd0, 32'h0000_0500);
    @(negedge clk);
    stall = 1'b1;
    drive(3'd0, 1'b0, 1'b1, 5'd14, 32'hBBBB_0002, 32'd0, 32'h0000_0504);
    n_hi = 0;
    for (int k = 0; k < 5; k++) begin
      if (write_enabled) n_hi++;
      chk("stall_hold_addr", {27'd0, write_addr}, 32'd13);
      @(negedge clk);
    end
    stall = 1'b0; mem_valid = 1'b0;
    chk("stall_we_once", n_hi, 32'd1);
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    chk("stall_count", retire_count, exp_count);

    // Misaligned load held by stall: one exception pulse, no write, no count.
    drive(3'd0, 1'b1, 1'b1, 5'd18, 32'h0000_3001, 32'h1234_5678, 32'h0000_0600);
    @(negedge clk);
    stall = 1'b1; mem_valid = 1'b0;
    n_hi = 0; n_mis = 0;
    for (int k = 0; k < 4; k++) begin
      if (write_enabled) n_hi++;
      if (misalign_exc) n_mis++;
      @(negedge clk);
    end
    stall = 1'b0;
    chk("mis_stall_pulse", n_mis, 32'd1);
    chk("mis_stall_we", n_hi, 32'd0);
    @(negedge clk);
    chk("mis_stall_count", retire_count, exp_count);

    // Flush on the presenting cycle: write still visible, entry and incoming gone.
    drive(3'd0, 1'b0, 1'b1, 5'd19, 32'h1111_0000, 32'd0, 32'h0000_0700);
    @(negedge clk);
    flush = 1'b1;
    drive(3'd0, 1'b0, 1'b1, 5'd20, 32'h2222_0000, 32'd0, 32'h0000_0704);
    chk("flush_we_now", {31'd0, write_enabled}, 32'd1);
    chk("flush_addr_now", {27'd0, write_addr}, 32'd19);
    @(negedge clk);
    flush = 1'b0; mem_valid = 1'b0;
    chk("flush_we_after", {31'd0, write_enabled}, 32'd0);
    chk("flush_addr_after", {27'd0, write_addr}, 32'd0);
    exp_count = exp_count + 32'd1;

    // Flush beats stall.
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b1, 5'd21, 32'h3333_0000, 32'd0, 32'h0000_0800);
    @(negedge clk);
    stall = 1'b1; flush = 1'b1; mem_valid = 1'b0;
    chk("fs_we_now", {31'd0, write_enabled}, 32'd1);
    @(negedge clk);
    chk("fs_we_after", {31'd0, write_enabled}, 32'd0);
    chk("fs_pc_after", wb_pc, 32'd0);
    stall = 1'b0; flush = 1'b0;
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    chk("fs_count", retire_count, exp_count);

    // Asynchronous reset in the middle of a stall.
    drive(3'd0, 1'b0, 1'b1, 5'd22, 32'h4444_0000, 32'd0, 32'h0000_0900);
    @(negedge clk);
    stall = 1'b1; mem_valid = 1'b0;
    chk("rstmid_we_before", {31'd0, write_enabled}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_we", {31'd0, write_enabled}, 32'd0);
    chk("rstmid_addr", {27'd0, write_addr}, 32'd0);
    chk("rstmid_data", write_data, 32'd0);
    chk("rstmid_count", retire_count, 32'd0);
    exp_count = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstrel_we1", {31'd0, write_enabled}, 32'd0);
    @(negedge clk);
    chk("rstrel_we2", {31'd0, write_enabled}, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    chk("rstrel_count", retire_count, exp_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
